rs_alu: RTL and testbench

ALU reservation station for the out-of-order core. Each cycle it reports which of its slots are empty as a bit vector, and the free-tag lookup table turns that vector into the lowest free slot index. The station writes the dispatched instruction into that slot and captures operands broadcast on the two common data buses (CDB). It issues the lowest-index fully-ready entry to the ALU through a registered valid/ready output stage.

---
 rtl/rs_alu_pkg.sv | 39 +++
 rtl/rs_select.sv | 23 ++
 rtl/rs_alu.sv | 117 +++++++++++
 tb/tb_rs_alu.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rs_alu_pkg.sv
// rtl/rs_alu_pkg.sv - shared sizes, encodings and operand capture helper for the ALU reservation station
package rs_alu_pkg;

  localparam int RS_SIZE = 6;
  localparam int ROOT_W  = 3;
  localparam int TAG_W   = 4;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 5;

  localparam logic [ROOT_W-1:0] NO_FREE_TAG = 3'b111;
  localparam logic              ALU_UNIT    = 1'b0;

  typedef struct packed {
    logic              rdy;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } opnd_t;

  // Snoop both CDBs for a waiting operand; cdb0 has priority when both match.
  function automatic opnd_t capture(input opnd_t cur,
                                    input logic c0_en, input logic [TAG_W-1:0] c0_tag,
                                    input logic [DATA_W-1:0] c0_data,
                                    input logic c1_en, input logic [TAG_W-1:0] c1_tag,
                                    input logic [DATA_W-1:0] c1_data);
    opnd_t res;
    res = cur;
    if (!cur.rdy) begin
      if (c0_en && (c0_tag == cur.tag)) begin
        res.rdy = 1'b1;
        res.val = c0_data;
      end else if (c1_en && (c1_tag == cur.tag)) begin
        res.rdy = 1'b1;
        res.val = c1_data;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rs_select.sv
// rtl/rs_select.sv - lowest-set-bit encoder over the entry ready vector
module rs_select #(
  parameter int N = 6,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_alu.sv
// rtl/rs_alu.sv - ALU reservation station with CDB wakeup, lowest-index select and registered issue stage
module rs_alu
  import rs_alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  output logic [RS_SIZE-1:0]  free_status,
  input  logic [ROOT_W-1:0]   free_tag,
  input  logic                disp_en,
  input  logic [OP_W-1:0]     disp_op,
  input  logic [DATA_W-1:0]   disp_val1,
  input  logic [DATA_W-1:0]   disp_val2,
  input  logic [TAG_W-1:0]    disp_tag1,
  input  logic [TAG_W-1:0]    disp_tag2,
  input  logic                disp_rdy1,
  input  logic                disp_rdy2,
  input  logic                cdb0_en,
  input  logic [TAG_W-1:0]    cdb0_tag,
  input  logic [DATA_W-1:0]   cdb0_data,
  input  logic                cdb1_en,
  input  logic [TAG_W-1:0]    cdb1_tag,
  input  logic [DATA_W-1:0]   cdb1_data,
  output logic                iss_valid,
  input  logic                iss_ready,
  output logic [OP_W-1:0]     iss_op,
  output logic [DATA_W-1:0]   iss_a,
  output logic [DATA_W-1:0]   iss_b,
  output logic [TAG_W-1:0]    iss_tag,
  output logic                full
);

  logic [RS_SIZE-1:0] valid;
  logic [OP_W-1:0]    op   [RS_SIZE];
  opnd_t              src1 [RS_SIZE];
  opnd_t              src2 [RS_SIZE];

  logic [RS_SIZE-1:0] ready_vec;
  logic [ROOT_W-1:0]  sel_idx;
  logic               sel_found;
  logic               load;
  logic               disp_ok;
  opnd_t              disp_src1;
  opnd_t              disp_src2;

  assign free_status = ~valid;
  assign full        = &valid;
  assign disp_ok     = disp_en && (free_tag != NO_FREE_TAG);
  assign load        = sel_found && (!iss_valid || iss_ready);

  // Per-entry readiness from registered state only; no same-cycle wakeup-to-select path.
  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = valid[i] & src1[i].rdy & src2[i].rdy;
    end
  end

  // Dispatch operands after bypassing any CDB broadcast in the same cycle.
  always_comb begin
    disp_src1 = capture('{rdy: disp_rdy1, tag: disp_tag1, val: disp_val1},
                        cdb0_en, cdb0_tag, cdb0_data, cdb1_en, cdb1_tag, cdb1_data);
    disp_src2 = capture('{rdy: disp_rdy2, tag: disp_tag2, val: disp_val2},
                        cdb0_en, cdb0_tag, cdb0_data, cdb1_en, cdb1_tag, cdb1_data);
  end

  rs_select #(.N(RS_SIZE), .W(ROOT_W)) u_select (
    .req   (ready_vec),
    .idx   (sel_idx),
    .found (sel_found)
  );

  // Entry array: free on move to issue, write on dispatch, otherwise snoop the CDBs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op[i]   <= '0;
        src1[i] <= '0;
        src2[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (load && (sel_idx == ROOT_W'(i))) begin
          valid[i] <= 1'b0;
        end else if (disp_ok && (free_tag == ROOT_W'(i))) begin
          valid[i] <= 1'b1;
          op[i]    <= disp_op;
          src1[i]  <= disp_src1;
          src2[i]  <= disp_src2;
        end else if (valid[i]) begin
          src1[i] <= capture(src1[i], cdb0_en, cdb0_tag, cdb0_data, cdb1_en, cdb1_tag, cdb1_data);
          src2[i] <= capture(src2[i], cdb0_en, cdb0_tag, cdb0_data, cdb1_en, cdb1_tag, cdb1_data);
        end
      end
    end
  end

  // Issue register: load when empty or draining, hold while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_valid <= 1'b0;
      iss_op    <= '0;
      iss_a     <= '0;
      iss_b     <= '0;
      iss_tag   <= '0;
    end else if (load) begin
      iss_valid <= 1'b1;
      iss_op    <= op[sel_idx];
      iss_a     <= src1[sel_idx].val;
      iss_b     <= src2[sel_idx].val;
      iss_tag   <= {ALU_UNIT, sel_idx};
    end else if (iss_ready) begin
      iss_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rs_alu.sv
// tb/tb_rs_alu.sv - directed self-checking bench for rs_alu
module tb_rs_alu;
  import rs_alu_pkg::*;

  logic                clk;
  logic                rst;
  logic [RS_SIZE-1:0]  free_status;
  logic [ROOT_W-1:0]   free_tag;
  logic                disp_en;
  logic [OP_W-1:0]     disp_op;
  logic [DATA_W-1:0]   disp_val1, disp_val2;
  logic [TAG_W-1:0]    disp_tag1, disp_tag2;
  logic                disp_rdy1, disp_rdy2;
  logic                cdb0_en, cdb1_en;
  logic [TAG_W-1:0]    cdb0_tag, cdb1_tag;
  logic [DATA_W-1:0]   cdb0_data, cdb1_data;
  logic                iss_valid, iss_ready;
  logic [OP_W-1:0]     iss_op;
  logic [DATA_W-1:0]   iss_a, iss_b;
  logic [TAG_W-1:0]    iss_tag;
  logic                full;

  int checks = 0;
  int errors = 0;

  rs_alu dut (
    .clk(clk), .rst(rst), .free_status(free_status), .free_tag(free_tag),
    .disp_en(disp_en), .disp_op(disp_op), .disp_val1(disp_val1), .disp_val2(disp_val2),
    .disp_tag1(disp_tag1), .disp_tag2(disp_tag2), .disp_rdy1(disp_rdy1), .disp_rdy2(disp_rdy2),
    .cdb0_en(cdb0_en), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
    .cdb1_en(cdb1_en), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_a(iss_a), .iss_b(iss_b), .iss_tag(iss_tag), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic disp(input logic [2:0] ft, input logic [4:0] o,
                      input logic [31:0] v1, input logic [3:0] t1, input logic r1,
                      input logic [31:0] v2, input logic [3:0] t2, input logic r2);
    disp_en = 1'b1; free_tag = ft; disp_op = o;
    disp_val1 = v1; disp_tag1 = t1; disp_rdy1 = r1;
    disp_val2 = v2; disp_tag2 = t2; disp_rdy2 = r2;
  endtask

  initial begin
    rst = 1'b0; free_tag = 3'd0; disp_en = 1'b0; disp_op = '0;
    disp_val1 = '0; disp_val2 = '0; disp_tag1 = '0; disp_tag2 = '0;
    disp_rdy1 = 1'b0; disp_rdy2 = 1'b0;
    cdb0_en = 1'b0; cdb0_tag = '0; cdb0_data = '0;
    cdb1_en = 1'b0; cdb1_tag = '0; cdb1_data = '0;
    iss_ready = 1'b1;
    step(); step();
    chk("rst_free", 32'(free_status), 32'h3F);
    chk("rst_iss_valid", 32'(iss_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_iss_a", iss_a, 32'd0);
    rst = 1'b1;
    step();

    // Ready add straight through
    disp(3'd0, 5'd1, 32'd5, 4'h0, 1'b1, 32'd7, 4'h0, 1'b1);
    step();
    disp_en = 1'b0;
    chk("a_free", 32'(free_status), 32'h3E);
    chk("a_valid_early", 32'(iss_valid), 32'd0);
    step();
    chk("a_valid", 32'(iss_valid), 32'd1);
    chk("a_a", iss_a, 32'd5);
    chk("a_b", iss_b, 32'd7);
    chk("a_tag", 32'(iss_tag), 32'd0);
    chk("a_op", 32'(iss_op), 32'd1);
    chk("a_freed", 32'(free_status), 32'h3F);
    step();
    chk("a_drained", 32'(iss_valid), 32'd0);

    // Wait on tag 1010, woken by cdb1
    disp(3'd0, 5'd2, 32'd3, 4'h0, 1'b1, 32'd0, 4'hA, 1'b0);
    step();
    disp_en = 1'b0;
    step(); step();
    chk("b_wait_free", 32'(free_status), 32'h3E);
    chk("b_wait_valid", 32'(iss_valid), 32'd0);
    cdb1_en = 1'b1; cdb1_tag = 4'hA; cdb1_data = 32'h1234;
    step();
    cdb1_en = 1'b0;
    chk("b_valid_early", 32'(iss_valid), 32'd0);
    step();
    chk("b_valid", 32'(iss_valid), 32'd1);
    chk("b_a", iss_a, 32'd3);
    chk("b_b", iss_b, 32'h1234);
    step();
    chk("b_drained", 32'(iss_valid), 32'd0);

    // Fill all entries with operands waiting on tag 0011
    for (int i = 0; i < 6; i++) begin
      disp(3'(i), 5'(i), 32'hFFFF_FFFF, 4'h3, 1'b0, 32'(i + 16), 4'h0, 1'b1);
      step();
    end
    disp_en = 1'b0;
    chk("c_full", 32'(full), 32'd1);
    chk("c_free", 32'(free_status), 32'h00);
    disp(3'd7, 5'd31, 32'hDEAD, 4'h0, 1'b1, 32'hBEEF, 4'h0, 1'b1);
    step();
    disp_en = 1'b0;
    chk("c_drop_free", 32'(free_status), 32'h00);
    chk("c_drop_valid", 32'(iss_valid), 32'd0);
    cdb0_en = 1'b1; cdb0_tag = 4'h3; cdb0_data = 32'h99;
    step();
    cdb0_en = 1'b0;
    chk("c_wake_valid", 32'(iss_valid), 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("c_b2b_valid", 32'(iss_valid), 32'd1);
      chk("c_b2b_tag", 32'(iss_tag), 32'(k));
      chk("c_b2b_op", 32'(iss_op), 32'(k));
      chk("c_b2b_a", iss_a, 32'h99);
      chk("c_b2b_b", iss_b, 32'(k + 16));
    end
    chk("c_all_free", 32'(free_status), 32'h3F);
    step();
    chk("c_drained", 32'(iss_valid), 32'd0);

    // Stall with two ready entries
    iss_ready = 1'b0;
    disp(3'd0, 5'd2, 32'h11, 4'h0, 1'b1, 32'h22, 4'h0, 1'b1);
    step();
    disp(3'd1, 5'd3, 32'h33, 4'h0, 1'b1, 32'h44, 4'h0, 1'b1);
    step();
    disp_en = 1'b0;
    chk("d_valid", 32'(iss_valid), 32'd1);
    chk("d_a", iss_a, 32'h11);
    chk("d_tag", 32'(iss_tag), 32'd0);
    chk("d_free", 32'(free_status), 32'h3D);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("d_hold_valid", 32'(iss_valid), 32'd1);
      chk("d_hold_a", iss_a, 32'h11);
      chk("d_hold_b", iss_b, 32'h22);
      chk("d_hold_tag", 32'(iss_tag), 32'd0);
      chk("d_hold_op", 32'(iss_op), 32'd2);
    end
    iss_ready = 1'b1;
    step();
    chk("d_next_valid", 32'(iss_valid), 32'd1);
    chk("d_next_a", iss_a, 32'h33);
    chk("d_next_tag", 32'(iss_tag), 32'd1);
    step();
    chk("d_drained", 32'(iss_valid), 32'd0);

    // Dispatch bypass; both CDBs carry the tag, cdb0 wins
    cdb0_en = 1'b1; cdb0_tag = 4'h5; cdb0_data = 32'hABCD;
    cdb1_en = 1'b1; cdb1_tag = 4'h5; cdb1_data = 32'h5555;
    disp(3'd0, 5'd4, 32'd0, 4'h5, 1'b0, 32'd0, 4'h5, 1'b0);
    step();
    disp_en = 1'b0; cdb0_en = 1'b0; cdb1_en = 1'b0;
    chk("e_valid_early", 32'(iss_valid), 32'd0);
    step();
    chk("e_valid", 32'(iss_valid), 32'd1);
    chk("e_a", iss_a, 32'hABCD);
    chk("e_b", iss_b, 32'hABCD);
    step();
    chk("e_drained", 32'(iss_valid), 32'd0);

    // Asynchronous reset mid-operation
    iss_ready = 1'b0;
    disp(3'd0, 5'd6, 32'h77, 4'h0, 1'b1, 32'h1, 4'h0, 1'b1);
    step();
    disp(3'd1, 5'd7, 32'h0, 4'h3, 1'b0, 32'h0, 4'h3, 1'b0);
    step();
    disp_en = 1'b0;
    chk("f_pre_valid", 32'(iss_valid), 32'd1);
    chk("f_pre_a", iss_a, 32'h77);
    chk("f_pre_free", 32'(free_status), 32'h3D);
    #2;
    rst = 1'b0;
    #1;
    chk("f_rst_valid", 32'(iss_valid), 32'd0);
    chk("f_rst_a", iss_a, 32'd0);
    chk("f_rst_free", 32'(free_status), 32'h3F);
    chk("f_rst_full", 32'(full), 32'd0);
    step();
    rst = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
